imem_arbiter: RTL and testbench

Two-requester arbiter and controller for the shared single-port instruction/data word memory (1024 x 32, word-addressed).
- Port 0 is the fetch stage (PC-driven reads).
- Port 1 is the loader/store path (program load and data stores).
- Round-robin arbitration, plus an optional burst lock for port 1.
- Registered 1-cycle read latency, matching the fetch stage's registered instruction fetch.

---
 rtl/rv32_mem_pkg.sv | 28 ++
 rtl/imem_ram.sv | 32 +++
 rtl/imem_arbiter.sv | 170 +++++++++++++++++
 tb/tb_imem_arbiter.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/rv32_mem_pkg.sv
// Shared definitions for the instruction/data word memory and its two-port arbiter.
// Holds the default geometry, port indices, arbiter state encoding and the round-robin pick.
package rv32_mem_pkg;

    localparam int IMEM_AW = 10;
    localparam int IMEM_DW = 32;

    localparam logic PORT_FETCH = 1'b0;
    localparam logic PORT_LSU   = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RR   = 2'd1,
        LOCK = 2'd2
    } arb_state_t;

    // Winner of a cycle: a lone requester wins; on a tie the port not granted last wins.
    function automatic logic rr_pick(input logic req0, input logic req1, input logic last_gnt);
        if (req0 && req1) begin
            return ~last_gnt;
        end else if (req1) begin
            return PORT_LSU;
        end else begin
            return PORT_FETCH;
        end
    endfunction

endpackage

// File: rtl/imem_ram.sv
// Single-port synchronous word RAM: one access per cycle, registered read data,
// write-enable selects write versus read. Contents are never reset.
module imem_ram
    import rv32_mem_pkg::*;
#(
    parameter int AW = IMEM_AW,
    parameter int DW = IMEM_DW
) (
    input  logic          clk,
    input  logic          en,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] wdata,
    output logic [DW-1:0] rdata
);

    localparam int DEPTH = 1 << AW;

    logic [DW-1:0] mem [DEPTH];

    // Read data only changes on a read access, so it stays stable across writes.
    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                mem[addr] <= wdata;
            end else begin
                rdata <= mem[addr];
            end
        end
    end

endmodule

// File: rtl/imem_arbiter.sv
// Round-robin arbiter in front of the shared instruction/data RAM (fetch = port 0, loader/store = port 1).
// Optional fetch starvation guard for port-1 burst lock: define IMEM_ARB_STARVE_GUARD_EN.
module imem_arbiter
    import rv32_mem_pkg::*;
#(
    parameter int AW       = IMEM_AW,
    parameter int DW       = IMEM_DW,
    parameter int MAX_LOCK = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req0,
    input  logic [AW-1:0] addr0,
    output logic          gnt0,
    output logic          rvalid0,
    output logic [DW-1:0] rdata0,
    input  logic          req1,
    input  logic          we1,
    input  logic          lock1,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wdata1,
    output logic          gnt1,
    output logic          rvalid1,
    output logic [DW-1:0] rdata1,
    output logic          busy
);

    localparam logic [1:0] S_IDLE = IDLE;
    localparam logic [1:0] S_RR   = RR;
    localparam logic [1:0] S_LOCK = LOCK;

    if (MAX_LOCK < 1) begin : g_bad_max_lock
        $error("imem_arbiter: MAX_LOCK must be at least 1");
    end

    logic [1:0]    state;
    logic [1:0]    state_nxt;
    logic          last_gnt;
    logic          lock_active;
    logic          force_gnt0;
    logic          pick;
    logic          any_req;

    logic          ram_en;
    logic          ram_we;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_q;

    logic          vld0_p1;
    logic          vld1_p1;
    logic [DW-1:0] hold0_p1;
    logic [DW-1:0] hold1_p1;

`ifdef IMEM_ARB_STARVE_GUARD_EN
    localparam int               CNT_W   = $clog2(MAX_LOCK + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_LOCK);

    logic [CNT_W-1:0] lock_cnt;
`endif

    // Grant decision and next state; a LOCK cycle with lock1 or req1 low arbitrates as plain RR.
    always_comb begin
        any_req     = req0 || req1;
        lock_active = (state == S_LOCK) && lock1 && req1;
        pick        = rr_pick(req0, req1, last_gnt);
        force_gnt0  = 1'b0;
`ifdef IMEM_ARB_STARVE_GUARD_EN
        force_gnt0  = lock_active && req0 && (lock_cnt == CNT_MAX);
`endif
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (force_gnt0) begin
            gnt0 = 1'b1;
        end else if (lock_active) begin
            gnt1 = 1'b1;
        end else if (any_req) begin
            gnt0 = (pick == PORT_FETCH);
            gnt1 = (pick == PORT_LSU);
        end

        if (!any_req) begin
            state_nxt = S_IDLE;
        end else if (lock_active || (gnt1 && lock1)) begin
            state_nxt = S_LOCK;
        end else begin
            state_nxt = S_RR;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            last_gnt <= PORT_LSU;
        end else begin
            state <= state_nxt;
            if (gnt0) begin
                last_gnt <= PORT_FETCH;
            end else if (gnt1) begin
                last_gnt <= PORT_LSU;
            end
        end
    end

`ifdef IMEM_ARB_STARVE_GUARD_EN
    // Counts locked port-1 beats, including the beat that entered LOCK.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lock_cnt <= '0;
        end else if (force_gnt0 || (state_nxt != S_LOCK)) begin
            lock_cnt <= '0;
        end else if (gnt1 && lock1 && (lock_cnt != CNT_MAX)) begin
            lock_cnt <= lock_cnt + 1'b1;
        end
    end
`endif

    assign busy = (state == S_LOCK);

    // ---- stage p0: grant mux into the RAM ----
    assign ram_en   = gnt0 || gnt1;
    assign ram_we   = gnt1 && we1;
    assign ram_addr = gnt1 ? addr1 : addr0;

    imem_ram #(
        .AW (AW),
        .DW (DW)
    ) u_ram (
        .clk   (clk),
        .en    (ram_en),
        .we    (ram_we),
        .addr  (ram_addr),
        .wdata (wdata1),
        .rdata (ram_q)
    );

    // ---- stage p1: read-data steering ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld0_p1 <= 1'b0;
            vld1_p1 <= 1'b0;
        end else begin
            vld0_p1 <= gnt0;
            vld1_p1 <= gnt1 && !we1;
        end
    end

    // The RAM output is shared, so each port keeps its own copy of the last word it read.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold0_p1 <= '0;
            hold1_p1 <= '0;
        end else begin
            if (vld0_p1) begin
                hold0_p1 <= ram_q;
            end
            if (vld1_p1) begin
                hold1_p1 <= ram_q;
            end
        end
    end

    assign rvalid0 = vld0_p1;
    assign rvalid1 = vld1_p1;
    assign rdata0  = vld0_p1 ? ram_q : hold0_p1;
    assign rdata1  = vld1_p1 ? ram_q : hold1_p1;

    a_gnt_exclusive: assert property (@(posedge clk) disable iff (rst) !(gnt0 && gnt1));
    a_rvalid_exclusive: assert property (@(posedge clk) disable iff (rst) !(rvalid0 && rvalid1));

endmodule

// File: tb/tb_imem_arbiter.sv
// Directed bench for imem_arbiter: reset, single read, write-then-read, round-robin ties,
// port-1 burst lock, asynchronous reset mid-operation and address wrap.
module tb_imem_arbiter;

    localparam int AW = 10;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          req0;
    logic [AW-1:0] addr0;
    logic          gnt0;
    logic          rvalid0;
    logic [DW-1:0] rdata0;
    logic          req1;
    logic          we1;
    logic          lock1;
    logic [AW-1:0] addr1;
    logic [DW-1:0] wdata1;
    logic          gnt1;
    logic          rvalid1;
    logic [DW-1:0] rdata1;
    logic          busy;

    int n_checks = 0;
    int n_pass   = 0;

    imem_arbiter #(.AW(AW), .DW(DW), .MAX_LOCK(8)) dut (
        .clk     (clk),
        .rst     (rst),
        .req0    (req0),
        .addr0   (addr0),
        .gnt0    (gnt0),
        .rvalid0 (rvalid0),
        .rdata0  (rdata0),
        .req1    (req1),
        .we1     (we1),
        .lock1   (lock1),
        .addr1   (addr1),
        .wdata1  (wdata1),
        .gnt1    (gnt1),
        .rvalid1 (rvalid1),
        .rdata1  (rdata1),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "bench did not finish");
    end

    task automatic drive_idle();
        req0  = 1'b0;
        req1  = 1'b0;
        we1   = 1'b0;
        lock1 = 1'b0;
    endtask

    task automatic write_word(input logic [AW-1:0] a, input logic [DW-1:0] d);
        @(negedge clk);
        req0 = 1'b0; req1 = 1'b1; we1 = 1'b1; lock1 = 1'b0; addr1 = a; wdata1 = d;
        @(posedge clk); #1;
        req1 = 1'b0; we1 = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; drive_idle(); addr0 = '0; addr1 = '0; wdata1 = '0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++; if (gnt0 !== 1'b0) $display("FAIL reset_gnt0 got=%b exp=0", gnt0); else n_pass++;
        n_checks++; if (gnt1 !== 1'b0) $display("FAIL reset_gnt1 got=%b exp=0", gnt1); else n_pass++;
        n_checks++; if (rvalid0 !== 1'b0) $display("FAIL reset_rvalid0 got=%b exp=0", rvalid0); else n_pass++;
        n_checks++; if (rvalid1 !== 1'b0) $display("FAIL reset_rvalid1 got=%b exp=0", rvalid1); else n_pass++;
        n_checks++; if (rdata0 !== 32'h0) $display("FAIL reset_rdata0 got=%h exp=0", rdata0); else n_pass++;
        n_checks++; if (rdata1 !== 32'h0) $display("FAIL reset_rdata1 got=%h exp=0", rdata1); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy got=%b exp=0", busy); else n_pass++;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic preload();
        write_word(10'd5,    32'h0204_0293);
        write_word(10'd10,   32'h1111_0000);
        write_word(10'd11,   32'h2222_0000);
        write_word(10'd1023, 32'hDEAD_BEEF);
        write_word(10'd0,    32'h0BAD_F00D);
    endtask

    // Writes leave last_gnt on port 1, so the first tie goes to fetch.
    task automatic test_round_robin();
        logic e0;
        @(negedge clk);
        req0 = 1'b1; req1 = 1'b1; we1 = 1'b0; lock1 = 1'b0; addr0 = 10'd10; addr1 = 10'd11;
        for (int k = 0; k < 4; k++) begin
            #1;
            e0 = (k % 2 == 0);
            n_checks++; if (gnt0 !== e0) $display("FAIL rr_gnt0[%0d] got=%b exp=%b", k, gnt0, e0); else n_pass++;
            n_checks++; if (gnt1 !== !e0) $display("FAIL rr_gnt1[%0d] got=%b exp=%b", k, gnt1, !e0); else n_pass++;
            @(posedge clk); #1;
            n_checks++; if (rvalid0 !== e0) $display("FAIL rr_rvalid0[%0d] got=%b exp=%b", k, rvalid0, e0); else n_pass++;
            n_checks++; if (rvalid1 !== !e0) $display("FAIL rr_rvalid1[%0d] got=%b exp=%b", k, rvalid1, !e0); else n_pass++;
            if (e0) begin
                n_checks++; if (rdata0 !== 32'h1111_0000) $display("FAIL rr_rdata0[%0d] got=%h exp=11110000", k, rdata0); else n_pass++;
            end else begin
                n_checks++; if (rdata1 !== 32'h2222_0000) $display("FAIL rr_rdata1[%0d] got=%h exp=22220000", k, rdata1); else n_pass++;
                n_checks++; if (rdata0 !== 32'h1111_0000) $display("FAIL rr_rdata0_hold[%0d] got=%h exp=11110000", k, rdata0); else n_pass++;
            end
            @(negedge clk);
        end
        drive_idle();
        #1;
        n_checks++; if ({gnt0, gnt1} !== 2'b00) $display("FAIL rr_idle_gnt got=%b exp=00", {gnt0, gnt1}); else n_pass++;
    endtask

    task automatic test_single_read();
        @(negedge clk);
        req0 = 1'b1; addr0 = 10'd5; #1;
        n_checks++; if (gnt0 !== 1'b1) $display("FAIL rd_gnt0 got=%b exp=1", gnt0); else n_pass++;
        n_checks++; if (gnt1 !== 1'b0) $display("FAIL rd_gnt1 got=%b exp=0", gnt1); else n_pass++;
        @(posedge clk); #1;
        n_checks++; if (rvalid0 !== 1'b1) $display("FAIL rd_rvalid0 got=%b exp=1", rvalid0); else n_pass++;
        n_checks++; if (rdata0 !== 32'h0204_0293) $display("FAIL rd_rdata0 got=%h exp=02040293", rdata0); else n_pass++;
        n_checks++; if (rvalid1 !== 1'b0) $display("FAIL rd_rvalid1 got=%b exp=0", rvalid1); else n_pass++;
        req0 = 1'b0;
        @(posedge clk); #1;
        n_checks++; if (rvalid0 !== 1'b0) $display("FAIL rd_rvalid0_drop got=%b exp=0", rvalid0); else n_pass++;
        n_checks++; if (rdata0 !== 32'h0204_0293) $display("FAIL rd_rdata0_hold got=%h exp=02040293", rdata0); else n_pass++;
    endtask

    task automatic test_write_then_read();
        @(negedge clk);
        req1 = 1'b1; we1 = 1'b1; addr1 = 10'd4; wdata1 = 32'h0081_0023; #1;
        n_checks++; if (gnt1 !== 1'b1) $display("FAIL wr_gnt1 got=%b exp=1", gnt1); else n_pass++;
        @(posedge clk); #1;
        n_checks++; if (rvalid1 !== 1'b0) $display("FAIL wr_rvalid1 got=%b exp=0", rvalid1); else n_pass++;
        req1 = 1'b0; we1 = 1'b0;
        @(negedge clk);
        req0 = 1'b1; addr0 = 10'd4;
        @(posedge clk); #1;
        n_checks++; if (rvalid0 !== 1'b1) $display("FAIL wr_rd_rvalid0 got=%b exp=1", rvalid0); else n_pass++;
        n_checks++; if (rdata0 !== 32'h0081_0023) $display("FAIL wr_rd_rdata0 got=%h exp=00810023", rdata0); else n_pass++;
        req0 = 1'b0;
    endtask

    // Entered with last_gnt on fetch, so the first tie goes to port 1 and starts the lock.
    task automatic test_lock();
        int  n;
        int  force_at;
        logic e0;
`ifdef IMEM_ARB_STARVE_GUARD_EN
        n = 13; force_at = 8;
`else
        n = 12; force_at = -1;
`endif
        @(negedge clk);
        req0 = 1'b1; addr0 = 10'd5; req1 = 1'b1; we1 = 1'b0; lock1 = 1'b1; addr1 = 10'd11;
        for (int k = 0; k < n; k++) begin
            #1;
            e0 = (k == force_at);
            n_checks++; if (gnt0 !== e0) $display("FAIL lock_gnt0[%0d] got=%b exp=%b", k, gnt0, e0); else n_pass++;
            n_checks++; if (gnt1 !== !e0) $display("FAIL lock_gnt1[%0d] got=%b exp=%b", k, gnt1, !e0); else n_pass++;
            n_checks++; if (busy !== (k != 0)) $display("FAIL lock_busy[%0d] got=%b exp=%b", k, busy, (k != 0)); else n_pass++;
            @(posedge clk); #1;
            n_checks++; if (rvalid1 !== !e0) $display("FAIL lock_rvalid1[%0d] got=%b exp=%b", k, rvalid1, !e0); else n_pass++;
            @(negedge clk);
        end
        lock1 = 1'b0; #1;
        n_checks++; if (gnt0 !== 1'b1) $display("FAIL unlock_gnt0 got=%b exp=1", gnt0); else n_pass++;
        n_checks++; if (busy !== 1'b1) $display("FAIL unlock_busy_pre got=%b exp=1", busy); else n_pass++;
        @(posedge clk); #1;
        n_checks++; if (busy !== 1'b0) $display("FAIL unlock_busy_post got=%b exp=0", busy); else n_pass++;
        n_checks++; if (rdata0 !== 32'h0204_0293) $display("FAIL unlock_rdata0 got=%h exp=02040293", rdata0); else n_pass++;
        @(negedge clk);
        drive_idle();
    endtask

    task automatic test_reset_midop();
        @(negedge clk);
        req1 = 1'b1; lock1 = 1'b1; we1 = 1'b0; addr1 = 10'd11;
        @(posedge clk); #1;
        n_checks++; if (busy !== 1'b1) $display("FAIL mid_lock_busy got=%b exp=1", busy); else n_pass++;
        #2 rst = 1'b1; #1;
        n_checks++; if (busy !== 1'b0) $display("FAIL mid_lock_abandon got=%b exp=0", busy); else n_pass++;
        @(negedge clk);
        drive_idle(); rst = 1'b0;
        @(negedge clk);
        req0 = 1'b1; addr0 = 10'd5;
        @(posedge clk); #1;
        n_checks++; if (rvalid0 !== 1'b1) $display("FAIL mid_rvalid0_pre got=%b exp=1", rvalid0); else n_pass++;
        req0 = 1'b0;
        #2 rst = 1'b1; #1;
        n_checks++; if (rvalid0 !== 1'b0) $display("FAIL mid_rvalid0_async got=%b exp=0", rvalid0); else n_pass++;
        n_checks++; if (rdata0 !== 32'h0) $display("FAIL mid_rdata0 got=%h exp=0", rdata0); else n_pass++;
        @(posedge clk); #1;
        n_checks++; if (rvalid0 !== 1'b0) $display("FAIL mid_rvalid0_next got=%b exp=0", rvalid0); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL mid_busy got=%b exp=0", busy); else n_pass++;
        @(negedge clk);
        rst = 1'b0; req0 = 1'b1; req1 = 1'b1; lock1 = 1'b0; addr0 = 10'd5; addr1 = 10'd11; #1;
        n_checks++; if (gnt0 !== 1'b1) $display("FAIL mid_tie_gnt0 got=%b exp=1", gnt0); else n_pass++;
        n_checks++; if (gnt1 !== 1'b0) $display("FAIL mid_tie_gnt1 got=%b exp=0", gnt1); else n_pass++;
        @(posedge clk); #1;
        n_checks++; if (rdata0 !== 32'h0204_0293) $display("FAIL mid_tie_rdata0 got=%h exp=02040293", rdata0); else n_pass++;
        n_checks++; if (rvalid1 !== 1'b0) $display("FAIL mid_tie_rvalid1 got=%b exp=0", rvalid1); else n_pass++;
        @(negedge clk);
        drive_idle();
    endtask

    task automatic test_back_to_back_wrap();
        @(negedge clk);
        req0 = 1'b1; addr0 = 10'd1023; #1;
        n_checks++; if (gnt0 !== 1'b1) $display("FAIL wrap_gnt0_a got=%b exp=1", gnt0); else n_pass++;
        @(posedge clk); #1;
        n_checks++; if (rvalid0 !== 1'b1) $display("FAIL wrap_rvalid0_a got=%b exp=1", rvalid0); else n_pass++;
        n_checks++; if (rdata0 !== 32'hDEAD_BEEF) $display("FAIL wrap_rdata0_a got=%h exp=deadbeef", rdata0); else n_pass++;
        @(negedge clk);
        addr0 = 10'd0; #1;
        n_checks++; if (gnt0 !== 1'b1) $display("FAIL wrap_gnt0_b got=%b exp=1", gnt0); else n_pass++;
        @(posedge clk); #1;
        n_checks++; if (rvalid0 !== 1'b1) $display("FAIL wrap_rvalid0_b got=%b exp=1", rvalid0); else n_pass++;
        n_checks++; if (rdata0 !== 32'h0BAD_F00D) $display("FAIL wrap_rdata0_b got=%h exp=0badf00d", rdata0); else n_pass++;
        req0 = 1'b0;
        @(posedge clk); #1;
        n_checks++; if (rvalid0 !== 1'b0) $display("FAIL wrap_rvalid0_end got=%b exp=0", rvalid0); else n_pass++;
    endtask

    initial begin
        test_reset();
        preload();
        test_round_robin();
        test_single_read();
        test_write_then_read();
        test_lock();
        test_reset_midop();
        test_back_to_back_wrap();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
